// File: rtl/ahb3lite_sram_slave.sv
// ahb3lite_sram_slave: AHB3-Lite slave terminating the bus into an internal
// word-addressed memory. Supports a fixed number of wait states per OKAY
// data phase and the two-cycle ERROR response for out-of-range, oversized
// or misaligned transfers.
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int NBYTES   = HDATA_SIZE / 8;
    localparam int ADDR_LSB = $clog2(NBYTES);
    localparam int IDX_W    = $clog2(MEM_DEPTH);

    localparam logic [3:0]            WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [HADDR_SIZE-1:0] ADDR_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Burst type, protection, lock and the BUSY/IDLE distinction do not
    // influence this slave's behaviour.
    logic unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_LSB-1:0]   off_q, off_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;

    logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

    logic                  accept;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    logic                  xfer_err;
    logic [HADDR_SIZE-1:0] word_idx;
    logic [HADDR_SIZE-1:0] align_mask;
    logic [NBYTES-1:0]     be;
    logic                  mem_we;

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    // Address-phase error decode: range, size and alignment.
    always_comb begin
        word_idx   = HADDR >> ADDR_LSB;
        align_mask = ~(ADDR_ONES << HSIZE);
        range_err  = (word_idx >= HADDR_SIZE'(MEM_DEPTH));
        size_err   = (HSIZE > 3'(ADDR_LSB));
        align_err  = ((HADDR & align_mask) != '0);
        xfer_err   = range_err | size_err | align_err;
    end

    // Next-state logic; IDLE, DATA and ERR2 share the accept rules so
    // transfers pipeline back to back.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d   = HADDR[ADDR_LSB +: IDX_W];
                    off_d   = HADDR[ADDR_LSB-1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // FSM, latched address phase and registered handshake outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            idx_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            size_q      <= size_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Byte lanes of the latched transfer: a lane is active when it lies in
    // the same 2^size block as the (aligned) start offset.
    always_comb begin
        be = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            be[b] = ((b >> size_q) == (32'(off_q) >> size_q));
        end
        mem_we = (state_q == ST_DATA) && write_q;
    end

    // Memory write at the closing edge of a write data phase; not reset.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is presented only in the completing cycle of a read.
    always_comb begin
        HRDATA = '0;
        if ((state_q == ST_DATA) && !write_q) begin
            HRDATA = mem_q[idx_q];
        end
    end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Testbench for ahb3lite_sram_slave: three instances (0, 2 and 3 wait
// states) driven by a pipelined AHB master, checked against a byte-level
// memory model and the transfer timing rules.
module tb_ahb3lite_sram_slave;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  burst;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        bus_sel;
    int          cur;

    logic [2:0]  hsel_v, rdy_v, resp_v;
    logic [31:0] rdata_v [3];

    int n_cmp = 0;
    int n_bad = 0;
    int busy, n_low, n_err_done;
    logic [31:0] last_rd;
    logic [31:0] model [3][256];
    xfer_t q[$];

    always #5 HCLK = ~HCLK;

    assign hsel_v[0] = bus_sel && (cur == 0);
    assign hsel_v[1] = bus_sel && (cur == 1);
    assign hsel_v[2] = bus_sel && (cur == 2);

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_v[0]), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata_v[0]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(rdy_v[0]), .HREADYOUT(rdy_v[0]),
        .HRESP(resp_v[0]));

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_v[1]), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata_v[1]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(rdy_v[1]), .HREADYOUT(rdy_v[1]),
        .HRESP(resp_v[1]));

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_v[2]), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(rdata_v[2]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(rdy_v[2]), .HREADYOUT(rdy_v[2]),
        .HRESP(resp_v[2]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut=%0d got=%0h exp=%0h t=%0t", tag, cur, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    // Error rule: word index out of range, size wider than the bus, or misaligned.
    function automatic bit spec_err(input logic [31:0] a, input logic [2:0] s);
        return ((a / 4) >= 256) || (s > 3'd2) || ((a % (32'd1 << s)) != 0);
    endfunction

    function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                 input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        xfer_t x;
        x.sel = sel; x.trans = tr; x.write = wr; x.size = sz;
        x.addr = a; x.wdata = wd; x.burst = 3'd0;
        return x;
    endfunction

    function automatic xfer_t rand_xfer();
        xfer_t x;
        int r;
        x.sel   = ($urandom_range(0, 9) != 0);
        r       = int'($urandom_range(0, 9));
        x.trans = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
        x.write = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        x.addr  = 32'($urandom_range(0, 255)) * 4;
        if ($urandom_range(0, 14) == 0) x.addr = x.addr + 32'h400;
        if ($urandom_range(0, 7) == 0)
            x.addr = x.addr + 32'($urandom_range(0, 3));
        else if (x.size == 3'd0)
            x.addr = x.addr + 32'($urandom_range(0, 3));
        else if (x.size == 3'd1)
            x.addr = x.addr + 32'($urandom_range(0, 1)) * 2;
        x.wdata = $urandom();
        x.burst = 3'($urandom_range(0, 7));
        return x;
    endfunction

    task automatic drive(input xfer_t x);
        bus_sel   = x.sel;
        HTRANS    = x.trans;
        HWRITE    = x.write;
        HSIZE     = x.size;
        HADDR     = x.addr;
        HBURST    = x.burst;
        HPROT     = 4'($urandom_range(0, 15));
        HMASTLOCK = 1'b0;
    endtask

    // Pipelined master: drives the queue into DUT `cur`; starts and ends
    // just after a rising edge with an idle address phase on the bus.
    task automatic run_q(input int max_cycles);
        xfer_t ap, dp;
        bit dp_v, dp_err, done;
        int dp_cyc, ws, idx, off;
        logic rdy, resp;
        logic [31:0] rd;
        ws = ws_of(cur);
        busy = 0; n_low = 0; n_err_done = 0;
        dp_v = 0; dp_err = 0; dp_cyc = 0; done = 0;
        dp = mk(0, 2'd0, 0, 3'd0, 32'd0, 32'd0);
        ap = (q.size() > 0) ? q.pop_front() : mk(0, 2'd0, 0, 3'd0, 32'd0, 32'd0);
        drive(ap);
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge HCLK);
            rdy  = rdy_v[cur];
            resp = resp_v[cur];
            rd   = rdata_v[cur];
            if (!rdy) n_low++;
            check_eq("hresp", 64'(resp), 64'(dp_v && dp_err));
            if (dp_v) begin
                busy++;
                dp_cyc++;
                if (rdy) begin
                    if (resp) n_err_done++;
                    check_eq("dp_cycles", 64'(dp_cyc), 64'(dp_err ? 2 : ws + 1));
                    idx = int'(dp.addr / 4);
                    off = int'(dp.addr % 4);
                    if (!dp_err && !dp.write) begin
                        check_eq("hrdata", 64'(rd), 64'(model[cur][idx]));
                        last_rd = rd;
                    end else begin
                        check_eq("hrdata_zero", 64'(rd), 64'd0);
                    end
                    if (!dp_err && dp.write) begin
                        for (int b = 0; b < 4; b++)
                            if (b >= off && b < off + (1 << dp.size))
                                model[cur][idx][8*b +: 8] = dp.wdata[8*b +: 8];
                    end
                    dp_v = 0;
                end else begin
                    check_eq("hrdata_wait", 64'(rd), 64'd0);
                end
            end else begin
                check_eq("hready_idle", 64'(rdy), 64'd1);
                check_eq("hrdata_idle", 64'(rd), 64'd0);
            end
            if (rdy) begin
                if (ap.sel && ap.trans[1]) begin
                    dp = ap; dp_v = 1; dp_cyc = 0;
                    dp_err = spec_err(ap.addr, ap.size);
                end
                ap = (q.size() > 0) ? q.pop_front() : mk(0, 2'd0, 0, 3'd0, 32'd0, 32'd0);
            end
            @(posedge HCLK); #1;
            drive(ap);
            HWDATA = dp.wdata;
            done = !dp_v && (q.size() == 0) && !(ap.sel && ap.trans[1]);
        end
        check_eq("run_done", 64'(done), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_old;
        HRESET = 1'b1;
        cur = 0;
        HWDATA = '0;
        drive(mk(0, 2'd0, 0, 3'd0, 32'd0, 32'd0));
        #3;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            check_eq("rst_hready", 64'(rdy_v[d]), 64'd1);
            check_eq("rst_hresp", 64'(resp_v[d]), 64'd0);
            check_eq("rst_hrdata", 64'(rdata_v[d]), 64'd0);
        end
        @(negedge HCLK);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        // Fill every word so the model is fully known.
        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int w = 0; w < 256; w++)
                q.push_back(mk(1, 2'd2, 1, 3'd2, 32'(w * 4), $urandom()));
            run_q(2000);
        end

        // Zero-wait write then back-to-back read of the same word.
        cur = 0;
        q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h40, 32'hDEADBEEF));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h40, 32'h0));
        run_q(20);
        check_eq("raw_data", 64'(last_rd), 64'hDEADBEEF);
        check_eq("raw_busy", 64'(busy), 64'd2);
        check_eq("raw_nolow", 64'(n_low), 64'd0);

        // Byte lane merge.
        q.push_back(mk(1, 2'd2, 1, 3'd2, 32'h8, 32'h11223344));
        q.push_back(mk(1, 2'd2, 1, 3'd0, 32'hA, 32'h00AA0000));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h8, 32'h0));
        run_q(20);
        check_eq("lane_data", 64'(last_rd), 64'h11AA3344);

        // Idle with select, and NONSEQ without select: no write, no waits.
        exp_old = model[0][8];
        q.push_back(mk(1, 2'd0, 1, 3'd2, 32'h20, 32'h55555555));
        q.push_back(mk(0, 2'd2, 1, 3'd2, 32'h20, 32'h66666666));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h20, 32'h0));
        run_q(20);
        check_eq("idle_nowrite", 64'(last_rd), 64'(exp_old));
        check_eq("idle_busy", 64'(busy), 64'd1);
        check_eq("idle_nolow", 64'(n_low), 64'd0);

        // Two wait states: single read, then a 4-beat INCR burst.
        cur = 1;
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h40, 32'h0));
        run_q(20);
        check_eq("ws2_low", 64'(n_low), 64'd2);
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h100, 32'h0));
        q.push_back(mk(1, 2'd3, 0, 3'd2, 32'h104, 32'h0));
        q.push_back(mk(1, 2'd3, 0, 3'd2, 32'h108, 32'h0));
        q.push_back(mk(1, 2'd3, 0, 3'd2, 32'h10C, 32'h0));
        foreach (q[i]) q[i].burst = 3'd3;
        run_q(40);
        check_eq("burst_busy", 64'(busy), 64'd12);

        // Error responses; memory at word 0 must be untouched.
        exp_old = model[1][0];
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h400, 32'h0));
        q.push_back(mk(1, 2'd2, 1, 3'd1, 32'h3, 32'hFFFFFFFF));
        q.push_back(mk(1, 2'd2, 0, 3'd3, 32'h0, 32'h0));
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h0, 32'h0));
        run_q(40);
        check_eq("err_count", 64'(n_err_done), 64'd3);
        check_eq("err_nowrite", 64'(last_rd), 64'(exp_old));

        // Reset in the middle of a three-wait-state write to 0x10.
        cur = 2;
        exp_old = model[2][4];
        drive(mk(1, 2'd2, 1, 3'd2, 32'h10, 32'h0));
        @(posedge HCLK); #1;
        drive(mk(0, 2'd0, 0, 3'd0, 32'd0, 32'd0));
        HWDATA = 32'hCAFEF00D;
        @(posedge HCLK); #1;
        check_eq("in_wait", 64'(rdy_v[2]), 64'd0);
        #2;
        HRESET = 1'b1;
        #1;
        check_eq("mrst_hready", 64'(rdy_v[2]), 64'd1);
        check_eq("mrst_hresp", 64'(resp_v[2]), 64'd0);
        check_eq("mrst_hrdata", 64'(rdata_v[2]), 64'd0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        q.push_back(mk(1, 2'd2, 0, 3'd2, 32'h10, 32'h0));
        run_q(20);
        check_eq("mrst_nowrite", 64'(last_rd), 64'(exp_old));

        // Randomized traffic on every instance.
        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int i = 0; i < 150; i++) q.push_back(rand_xfer());
            run_q(1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
